// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: receiver state
// encoding and the baud-rate constants for the 6 MHz system clock
// (48 MHz HFOSC divided by 8).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int SYS_CLK_HZ           = 6_000_000;
    localparam int BAUD                 = 9600;
    localparam int CLKS_PER_BIT_DEFAULT = SYS_CLK_HZ / BAUD;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk    in   destination clock
//   reset  in   synchronous, active-high; both flops load RESET_VAL
//   d      in   asynchronous input
//   q      out  synchronized output, two clocks of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state is written with non-blocking assignments so both
    // flops sample their inputs from before the edge, forming a real 2-stage
    // shift rather than a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first. Samples the asynchronous rx pin at bit
// centres and hands bytes to the consumer over a valid/ready interface.
// Ports:
//   clk        in   system clock (6 MHz)
//   reset      in   synchronous, active-high
//   rx         in   asynchronous serial input, idles high
//   data       out  received byte, stable while valid=1
//   valid      out  data holds an unconsumed byte
//   ready      in   consumer takes data on a valid && ready cycle
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun    out  sticky: a byte was dropped because data was still held
//   busy       out  receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // The counter restarts at 0 on each state entry, so a value of N-1 marks
    // the Nth cycle spent in that state.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    rx_state_t              state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // A handshake consumes the held byte and clears overrun. A byte
            // delivered on the same edge overrides the valid clear below.
            // NOTE: when one always_ff makes several non-blocking assignments
            // to the same flop, the last one executed on that edge wins.
            if (valid && ready) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            // A byte can load if the slot is empty or is being
                            // emptied by a handshake on this same edge.
                            if (!valid || ready) begin
                                data  <= shift_q;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Wait out a held-low line so a break yields a single error.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx with CLKS_PER_BIT = 8.
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, and valid/frame_err cycles are counted on falling edges.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Written only by the monitor; the stimulus takes snapshots and compares
    // differences.
    int         valid_cnt = 0;
    int         fe_cnt    = 0;
    logic [7:0] last_data = 8'h00;

    int base_v;
    int base_fe;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = data;
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call 1 time unit after a rising edge. Each bit lasts CPB clocks. With
    // pulse_rdy set, ready is high for exactly the stop-sample cycle, i.e.
    // the edge on which the byte is delivered. Returns 2 clocks after that
    // delivery edge... minus one: the call ends 1 clock after delivery.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pulse_rdy);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB - 2);
        if (pulse_rdy) ready = 1'b1;
        step(1);
        if (pulse_rdy) ready = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        step(3);

        // Reset state
        check("rst_data",    {24'h0, data}, 32'h00);
        check("rst_valid",   {31'h0, valid}, 32'h0);
        check("rst_ferr",    {31'h0, frame_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_busy",    {31'h0, busy}, 32'h0);
        reset = 1'b0;
        step(4);

        // Good frame 0xA5 with ready held high: one valid cycle
        base_v  = valid_cnt;
        base_fe = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_valid_cycles", valid_cnt - base_v, 1);
        check("a5_data",         {24'h0, last_data}, 32'hA5);
        check("a5_ferr",         fe_cnt - base_fe, 0);
        check("a5_overrun",      {31'h0, overrun}, 32'h0);
        check("a5_busy_after",   {31'h0, busy}, 32'h0);
        step(4);

        // One-cycle glitch: start is rejected at mid start bit
        base_v  = valid_cnt;
        base_fe = fe_cnt;
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(4);
        check("glitch_busy_start", {31'h0, busy}, 32'h1);
        step(2);
        check("glitch_busy_idle",  {31'h0, busy}, 32'h0);
        step(10);
        check("glitch_no_valid",   valid_cnt - base_v, 0);
        check("glitch_no_ferr",    fe_cnt - base_fe, 0);

        // 0x3C with a low stop bit, then a 40-cycle break, then 0x81
        base_v  = valid_cnt;
        base_fe = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        step(40);
        check("brk_busy_held",  {31'h0, busy}, 32'h1);
        rx = 1'b1;
        step(4);
        check("brk_busy_idle",  {31'h0, busy}, 32'h0);
        check("brk_ferr_once",  fe_cnt - base_fe, 1);
        check("brk_no_byte",    valid_cnt - base_v, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        check("brk_81_cycles",  valid_cnt - base_v, 1);
        check("brk_81_data",    {24'h0, last_data}, 32'h81);
        check("brk_ferr_total", fe_cnt - base_fe, 1);
        step(4);

        // Overrun: 0x11 held, 0x22 dropped
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_data",  {24'h0, data}, 32'h11);
        check("ovr_valid", {31'h0, valid}, 32'h1);
        check("ovr_flag",  {31'h0, overrun}, 32'h1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check("ovr_hs_valid",   {31'h0, valid}, 32'h0);
        check("ovr_hs_overrun", {31'h0, overrun}, 32'h0);
        step(4);

        // Handshake on the delivery edge: new byte replaces the old one
        send_frame(8'h11, 1'b1, 1'b0);
        check("same_pre_data",  {24'h0, data}, 32'h11);
        check("same_pre_valid", {31'h0, valid}, 32'h1);
        send_frame(8'h22, 1'b1, 1'b1);
        check("same_data",    {24'h0, data}, 32'h22);
        check("same_valid",   {31'h0, valid}, 32'h1);
        check("same_overrun", {31'h0, overrun}, 32'h0);
        send_frame(8'h33, 1'b1, 1'b0);
        check("pre_rst_overrun", {31'h0, overrun}, 32'h1);
        check("pre_rst_data",    {24'h0, data}, 32'h22);

        // Reset during data bit 4 of 0xFF, then 0x5A
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            step(CPB);
        end
        step(4);
        check("mid_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        step(1);
        check("mid_rst_data",    {24'h0, data}, 32'h00);
        check("mid_rst_valid",   {31'h0, valid}, 32'h0);
        check("mid_rst_ferr",    {31'h0, frame_err}, 32'h0);
        check("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        check("mid_rst_busy",    {31'h0, busy}, 32'h0);
        step(1);
        reset = 1'b0;
        step(40);
        check("post_rst_busy",  {31'h0, busy}, 32'h0);
        check("post_rst_valid", {31'h0, valid}, 32'h0);
        ready   = 1'b1;
        base_v  = valid_cnt;
        base_fe = fe_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        check("5a_cycles",  valid_cnt - base_v, 1);
        check("5a_data",    {24'h0, last_data}, 32'h5A);
        check("5a_ferr",    fe_cnt - base_fe, 0);
        check("5a_overrun", {31'h0, overrun}, 32'h0);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
